// File: rtl/sprite_defs.sv
// Shared definitions for the sprite evaluator and the sprite line renderer:
// table size, hit descriptor layout and evaluator state encodings.
package sprite_defs;

    localparam int SPR_COUNT = 64;
    localparam int SPR_SEL_W = 6;

    localparam int HIT_X_W   = 9;
    localparam int HIT_IDX_W = 10;
    localparam int HIT_ROW_W = 4;
    localparam int HIT_PAL_W = 2;
    localparam int HIT_W     = 33;

    localparam int HIT_HFLIP_LSB = 0;
    localparam int HIT_PRI_LSB   = 1;
    localparam int HIT_PAL_LSB   = 2;
    localparam int HIT_ROW_LSB   = 4;
    localparam int HIT_IDX_LSB   = 8;
    localparam int HIT_X_LSB     = 18;
    localparam int HIT_SEL_LSB   = 27;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } eval_state_t;

    function automatic logic [HIT_W-1:0] pack_hit(
        input logic [SPR_SEL_W-1:0] sel,
        input logic [HIT_X_W-1:0]   x,
        input logic [HIT_IDX_W-1:0] idx,
        input logic [HIT_ROW_W-1:0] row,
        input logic [HIT_PAL_W-1:0] pal,
        input logic                 pri,
        input logic                 hflip
    );
        logic [HIT_W-1:0] h;
        h = '0;
        h[HIT_SEL_LSB +: SPR_SEL_W] = sel;
        h[HIT_X_LSB   +: HIT_X_W]   = x;
        h[HIT_IDX_LSB +: HIT_IDX_W] = idx;
        h[HIT_ROW_LSB +: HIT_ROW_W] = row;
        h[HIT_PAL_LSB +: HIT_PAL_W] = pal;
        h[HIT_PRI_LSB]              = pri;
        h[HIT_HFLIP_LSB]            = hflip;
        return h;
    endfunction

endpackage

// File: rtl/sprite_hit_fifo.sv
// First-word-fall-through FIFO for hit descriptors; storage is plain
// distributed RAM, pointers reset asynchronously and clear on flush.
module sprite_hit_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && o_valid;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluator: walks the 64 attribute entries once per
// line_start and queues up to MAX_HITS render descriptors for the renderer.
//   state   | meaning
//   IDLE    | waiting for line_start, spr_sel holds its last value
//   SCAN    | evaluating sprite spr_sel this cycle, one entry per clock
module sprite_eval
    import sprite_defs::*;
#(
    parameter int MAX_HITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic [7:0]           next_line,
    output logic [SPR_SEL_W-1:0] spr_sel,
    input  logic [8:0]           spr_x,
    input  logic [7:0]           spr_y,
    input  logic [9:0]           spr_idx,
    input  logic                 spr_priority,
    input  logic [1:0]           spr_palette,
    input  logic                 spr_h16,
    input  logic                 spr_vflip,
    input  logic                 spr_hflip,
    output logic                 hit_valid,
    input  logic                 hit_ready,
    output logic [HIT_W-1:0]     hit_data,
    output logic                 eval_busy,
    output logic                 eval_done,
    output logic                 spr_overflow
);
    localparam int CNT_W = $clog2(MAX_HITS) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HITS);

    eval_state_t          r_state;
    eval_state_t          w_state_next;
    logic [7:0]           r_line;
    logic [SPR_SEL_W-1:0] r_sel;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic                 r_overflow;
    logic                 r_done;

    logic                 w_scan;
    logic                 w_last;
    logic [7:0]           w_row8;
    logic [3:0]           w_hmax;
    logic                 w_hit;
    logic [3:0]           w_row;
    logic                 w_room;
    logic                 w_push;
    logic [HIT_W-1:0]     w_entry;

    assign w_scan = (r_state == ST_SCAN);
    assign w_last = (r_sel == SPR_SEL_W'(SPR_COUNT - 1));

    // Mod-256 subtraction lets sprites straddle the Y=255 -> 0 boundary.
    assign w_row8 = r_line - spr_y;
    assign w_hmax = spr_h16 ? 4'd15 : 4'd7;
    assign w_hit  = w_scan && (w_row8 <= {4'b0000, w_hmax});
    assign w_row  = spr_vflip ? (w_hmax - w_row8[3:0]) : w_row8[3:0];
    assign w_room = (r_hit_cnt < MAX_CNT);
    assign w_push = w_hit && w_room && !line_start;

    assign w_entry = pack_hit(r_sel, spr_x, spr_idx, w_row, spr_palette,
                              spr_priority, spr_hflip);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (line_start) w_state_next = ST_SCAN;
            ST_SCAN: begin
                if (line_start)  w_state_next = ST_SCAN;
                else if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line     <= '0;
            r_sel      <= '0;
            r_hit_cnt  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else if (line_start) begin
            r_line     <= next_line;
            r_sel      <= '0;
            r_hit_cnt  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_scan && w_last;
            if (w_scan && !w_last) r_sel <= r_sel + 1'b1;
            if (w_hit) begin
                if (w_room) r_hit_cnt  <= r_hit_cnt + 1'b1;
                else        r_overflow <= 1'b1;
            end
        end
    end

    sprite_hit_fifo #(
        .WIDTH (HIT_W),
        .DEPTH (MAX_HITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (line_start),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (hit_ready),
        .o_valid (hit_valid),
        .o_data  (hit_data)
    );

    assign spr_sel      = r_sel;
    assign eval_busy    = w_scan;
    assign eval_done    = r_done;
    assign spr_overflow = r_overflow;

endmodule

// File: tb/tb_sprite_eval.sv
// Directed bench for sprite_eval: behavioural attribute RAM, hand-computed
// descriptors, scan timing, overflow, abort and async reset.
module tb_sprite_eval;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  next_line = '0;
    logic [5:0]  spr_sel;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic [9:0]  spr_idx;
    logic        spr_priority, spr_h16, spr_vflip, spr_hflip;
    logic [1:0]  spr_palette;
    logic        hit_valid;
    logic        hit_ready = 1'b0;
    logic [32:0] hit_data;
    logic        eval_busy, eval_done, spr_overflow;

    logic [8:0] t_x     [64];
    logic [7:0] t_y     [64];
    logic [9:0] t_idx   [64];
    logic [1:0] t_pal   [64];
    logic       t_pri   [64];
    logic       t_h16   [64];
    logic       t_vflip [64];
    logic       t_hflip [64];

    assign spr_x        = t_x[spr_sel];
    assign spr_y        = t_y[spr_sel];
    assign spr_idx      = t_idx[spr_sel];
    assign spr_palette  = t_pal[spr_sel];
    assign spr_priority = t_pri[spr_sel];
    assign spr_h16      = t_h16[spr_sel];
    assign spr_vflip    = t_vflip[spr_sel];
    assign spr_hflip    = t_hflip[spr_sel];

    always #5 clk = ~clk;

    sprite_eval #(.MAX_HITS(16)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
        .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
        .spr_priority(spr_priority), .spr_palette(spr_palette), .spr_h16(spr_h16),
        .spr_vflip(spr_vflip), .spr_hflip(spr_hflip), .hit_valid(hit_valid),
        .hit_ready(hit_ready), .hit_data(hit_data), .eval_busy(eval_busy),
        .eval_done(eval_done), .spr_overflow(spr_overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] q[$];
    int first_valid;
    logic ovf_c1, valid_c1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default();
        for (int i = 0; i < 64; i++) begin
            t_x[i]     = 9'(i * 7);
            t_y[i]     = 8'd200;
            t_idx[i]   = 10'(i + 100);
            t_pal[i]   = 2'(i % 4);
            t_pri[i]   = 1'(i % 2);
            t_hflip[i] = 1'((i / 2) % 2);
            t_h16[i]   = 1'b0;
            t_vflip[i] = 1'b0;
        end
    endtask

    function automatic logic [32:0] exp_entry(input int s, input logic [3:0] row);
        return {6'(s), t_x[s], t_idx[s], row, t_pal[s], t_pri[s], t_hflip[s]};
    endfunction

    // mode: 0 = ready held low, 1 = random ready, 2 = ready held high
    task automatic run_scan(input string tag, input logic [7:0] lin, input int mode);
        int done_cnt, done_cyc;
        done_cnt = 0;
        done_cyc = -1;
        first_valid = -1;
        q.delete();
        hit_ready  = 1'b0;
        line_start = 1'b1;
        next_line  = lin;
        tick();
        line_start = 1'b0;
        chk({tag, ".busy_c1"}, eval_busy, 1);
        chk({tag, ".sel_c1"}, spr_sel, 0);
        ovf_c1   = spr_overflow;
        valid_c1 = hit_valid;
        for (int c = 1; c <= 70; c++) begin
            if (c == 33) chk({tag, ".sel_c33"}, spr_sel, 32);
            if (c == 64) chk({tag, ".sel_c64"}, spr_sel, 63);
            if (c == 65) chk({tag, ".busy_c65"}, eval_busy, 0);
            if (eval_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (hit_valid && first_valid < 0) first_valid = c;
            if (c == 70 || mode == 0) hit_ready = 1'b0;
            else if (mode == 1)       hit_ready = 1'($urandom_range(0, 1));
            else                      hit_ready = 1'b1;
            if (hit_valid && hit_ready) q.push_back(hit_data);
            if (c < 70) tick();
        end
        hit_ready = 1'b0;
        chk({tag, ".done_cyc"}, done_cyc, 65);
        chk({tag, ".done_cnt"}, done_cnt, 1);
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            hit_ready = 1'b1;
            if (!hit_valid) break;
            q.push_back(hit_data);
            tick();
        end
        hit_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs[10];
        int done_cnt, done_cyc;
        hs = '{2, 7, 9, 15, 22, 30, 41, 50, 58, 63};
        set_default();
        tick();
        tick();
        chk("rst.sel", spr_sel, 0);
        chk("rst.busy", eval_busy, 0);
        chk("rst.done", eval_done, 0);
        chk("rst.ovf", spr_overflow, 0);
        chk("rst.valid", hit_valid, 0);
        reset = 1'b0;
        tick();

        // single hit, sprite 5 at y=10, line 12 -> row 2
        t_y[5] = 8'd10;
        run_scan("t1", 8'd12, 0);
        chk("t1.first_valid", first_valid, 7);
        drain(40);
        chk("t1.count", q.size(), 1);
        if (q.size() > 0)
            chk("t1.entry", q[0], {6'd5, 9'd35, 10'd105, 4'd2, 2'd1, 1'b1, 1'b0});

        // Y wrap with 16-tall vflipped sprite, then the same at height 8
        set_default();
        t_y[3] = 8'd250; t_h16[3] = 1'b1; t_vflip[3] = 1'b1;
        run_scan("t2a", 8'd4, 2);
        drain(40);
        chk("t2a.count", q.size(), 1);
        if (q.size() > 0)
            chk("t2a.entry", q[0], {6'd3, 9'd21, 10'd103, 4'd5, 2'd3, 1'b1, 1'b1});
        t_h16[3] = 1'b0;
        run_scan("t2b", 8'd4, 2);
        drain(40);
        chk("t2b.count", q.size(), 0);

        // overflow: 20 sprites on line 0, 16 accepted
        set_default();
        for (int i = 0; i < 20; i++) t_y[i] = 8'd0;
        run_scan("t3a", 8'd0, 0);
        chk("t3a.ovf", spr_overflow, 1);
        chk("t3a.valid", hit_valid, 1);
        drain(40);
        chk("t3a.count", q.size(), 16);
        chk("t3a.ovf_sticky", spr_overflow, 1);
        for (int i = 0; i < q.size(); i++)
            chk($sformatf("t3a.sel%0d", i), q[i][32:27], i);
        run_scan("t3b", 8'd0, 0);
        chk("t3b.valid", hit_valid, 1);
        run_scan("t3c", 8'd100, 0);
        chk("t3c.ovf_c1", ovf_c1, 0);
        chk("t3c.valid_c1", valid_c1, 0);

        // 10 hits under random backpressure; odd-numbered hits vflipped
        set_default();
        for (int i = 0; i < 10; i++) begin
            t_y[hs[i]]     = 8'd20;
            t_vflip[hs[i]] = 1'(i % 2);
        end
        run_scan("t4", 8'd25, 1);
        drain(40);
        chk("t4.count", q.size(), 10);
        if (q.size() == 10)
            for (int i = 0; i < 10; i++)
                chk($sformatf("t4.e%0d", i), q[i], exp_entry(hs[i], (i % 2) ? 4'd2 : 4'd5));

        // abort at cycle 30
        set_default();
        t_y[2] = 8'd50;
        line_start = 1'b1; next_line = 8'd50;
        tick();
        line_start = 1'b0;
        done_cnt = 0; done_cyc = -1;
        for (int c = 1; c < 30; c++) begin
            if (eval_done) done_cnt++;
            tick();
        end
        chk("t5.valid_c30", hit_valid, 1);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("t5.sel_c31", spr_sel, 0);
        chk("t5.valid_c31", hit_valid, 0);
        for (int c = 31; c <= 100; c++) begin
            if (eval_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            tick();
        end
        chk("t5.done_cnt", done_cnt, 1);
        chk("t5.done_cyc", done_cyc, 95);

        // async reset mid-scan
        set_default();
        for (int i = 0; i < 20; i++) t_y[i] = 8'd0;
        line_start = 1'b1; next_line = 8'd0;
        tick();
        line_start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        chk("t6.pre_ovf", spr_overflow, 1);
        chk("t6.pre_valid", hit_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.sel", spr_sel, 0);
        chk("t6.busy", eval_busy, 0);
        chk("t6.done", eval_done, 0);
        chk("t6.ovf", spr_overflow, 0);
        chk("t6.valid", hit_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6.post_busy", eval_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
